sd_spi_responder: RTL and testbench
===================================

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter NCR, default 1: number of 0xFF filler bytes between the last command byte and the first response byte (legal 1..8).
REQ-002 Parameter INIT_RETRIES, default 2: number of ACMD41 commands that return "idle" before the card reports ready (legal 1..15).
REQ-003 clk  input  1  system clock; SHALL run at least 8x the sclk frequency.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sclk  input  1  SPI clock from the master, mode 0, asynchronous to clk.
REQ-006 ss  input  1  slave select, active low, asynchronous.
REQ-007 mosi  input  1  master-to-card data, MSB first.
REQ-008 miso  output  1  card-to-master data, MSB first; 1 when idle.
REQ-009 cmd_valid  output  1  one-clk pulse when a complete command frame has been accepted.
REQ-010 cmd_index  output  6  index of the last accepted command.
REQ-011 cmd_arg  output  32  argument of the last accepted command.
REQ-012 card_idle  output  1  current in-idle-state flag of the card model.

Function
REQ-013 sclk, ss and mosi SHALL each pass through a 2-FF synchronizer; sclk edges SHALL be detected from the synchronized signal.
REQ-014 mosi SHALL be sampled on synchronized sclk rising edges; miso SHALL change only on falling edges, or when ss goes low.
REQ-015 ss high SHALL clear the bit counter, return the parser to HUNT and force miso=1 while keeping card state; the byte count restarts at 0 when ss falls.
REQ-016 Parser states: HUNT, CMD (bytes 2..6), WAIT (NCR filler), RESP (response bytes), then back to HUNT.
REQ-017 HUNT: a received byte with bits[7:6]=01 SHALL start a frame and supply cmd_index from bits[5:0]; any other byte SHALL be ignored.
REQ-018 CMD: bytes 2-5 SHALL form the argument, MSB first; byte 6 SHALL be the CRC byte, with crc[7:1]=CRC7 and crc[0]=end bit.
REQ-019 CRC7 (polynomial x^7+x^3+1, init 0) SHALL be computed serially over the first 40 bits.
REQ-020 The CRC SHALL be checked only for CMD0 and CMD8; a mismatch or end bit=0 SHALL give R1=0x08|card_idle with no state change.
REQ-021 CMD0: card_idle<=1, app flag cleared, retry counter cleared, R1=0x01.
REQ-022 CMD8: R7 = R1 (0x00|card_idle), then 0x00, 0x00, {4'h0,arg[11:8]}, arg[7:0].
REQ-023 CMD55: app flag<=1, R1=card_idle.
REQ-024 ACMD41 (CMD41 with app flag set): the retry counter SHALL increment; card_idle SHALL clear on the INIT_RETRIES-th ACMD41; R1 SHALL reflect card_idle after the update.
REQ-025 Any other command: R1=0x04|card_idle.
REQ-026 The app flag SHALL clear after any command other than CMD55.
REQ-027 cmd_valid SHALL pulse and cmd_index/cmd_arg SHALL update one clk after the 48th rising edge, for every frame including CRC-error frames.
REQ-028 WAIT: the master clocks NCR filler bytes while miso=1.
REQ-029 RESP: the MSB of R1 SHALL appear on the falling edge that ends the last filler byte; subsequent bytes follow back-to-back.
REQ-030 mosi bytes received during WAIT/RESP SHALL be ignored.
REQ-031 After the last response bit, miso SHALL return to 1 on the next falling edge, and the parser SHALL enter HUNT.
REQ-032 ss rising mid-frame or mid-response SHALL abort the frame with no card-state change and no cmd_valid.
REQ-033 The bit counter SHALL wrap 7->0 per byte, and the byte counter SHALL saturate so that continuous 0xFF clocking in HUNT never starts a frame.

Reset
REQ-034 rst asserted SHALL immediately force: miso=1, cmd_valid=0, cmd_index=0, cmd_arg=0, card_idle=1, app flag=0, retry counter=0, parser=HUNT, synchronizers=idle (sclk=0, ss=1).
REQ-035 rst asserted mid-response SHALL drop the response; after release, the first valid frame SHALL be decoded normally.

Verification
REQ-036 Send 40 00 00 00 00 95 -> one FF byte, then 01; cmd_valid pulses once with cmd_index=0; card_idle=1.
REQ-037 Send 48 00 00 01 AA 87 -> FF, then 01 00 00 01 AA.
REQ-038 Send 40 00 00 00 00 00 (bad CRC) -> response 09; cmd_valid pulses with cmd_index=0.
REQ-039 Send CMD55 (77 00 00 00 00 FF) then 69 40 00 00 00 FF, repeated twice -> responses 01, 01, 01, 00; card_idle falls after the second ACMD41.
REQ-040 Send CMD17 (51 00 00 00 00 FF) -> 05.
REQ-041 Raise ss after 3 bytes of a frame, then send a full CMD0 -> no cmd_valid for the aborted frame, then FF 01.
REQ-042 Assert rst during RESP -> miso=1 at once; a following CMD0 -> FF 01.

Source files
------------

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SPI-mode SD card command responder (CMD0/8/55/ACMD41)

// One serial step of CRC7 (x^7 + x^3 + 1), MSB-first data.
module sd_crc7_step (
  input  logic [6:0] crc_in,
  input  logic       din,
  output logic [6:0] crc_out
);
  logic fb;
  assign fb      = din ^ crc_in[6];
  assign crc_out = {crc_in[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
endmodule

module sd_spi_responder #(
  parameter int NCR          = 1,
  parameter int INIT_RETRIES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_idle
);

  typedef enum logic [1:0] {HUNT, CMD, WAIT, RESP} state_t;

  localparam logic [3:0] NCR_LAST  = 4'(NCR - 1);
  localparam logic [3:0] RETRY_LIM = 4'(INIT_RETRIES);

  logic        sclk_meta, sclk_sync, sclk_prev;
  logic        ss_meta, ss_sync;
  logic        mosi_meta, mosi_sync;
  logic        rise, fall, byte_done, frame_done;
  logic [7:0]  rx_byte, rx_shift;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_cnt;
  state_t      state, state_d;
  logic [6:0]  crc_q, crc_seed, crc_next;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic        app_q;
  logic [3:0]  retry_q, retry_inc, retry_d;
  logic        idle_d, app_d, crc_ok, long_resp;
  logic [7:0]  r1;
  logic [39:0] tx_q;
  logic [5:0]  tx_bits;

  // Bring the asynchronous SPI pins into the clk domain; sclk also keeps a delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_meta <= 1'b0; sclk_sync <= 1'b0; sclk_prev <= 1'b0;
      ss_meta   <= 1'b1; ss_sync   <= 1'b1;
      mosi_meta <= 1'b1; mosi_sync <= 1'b1;
    end else begin
      sclk_meta <= sclk;  sclk_sync <= sclk_meta; sclk_prev <= sclk_sync;
      ss_meta   <= ss;    ss_sync   <= ss_meta;
      mosi_meta <= mosi;  mosi_sync <= mosi_meta;
    end
  end

  assign rise       = sclk_sync & ~sclk_prev & ~ss_sync;
  assign fall       = ~sclk_sync & sclk_prev & ~ss_sync;
  assign byte_done  = rise && (bit_cnt == 3'd7);
  assign rx_byte    = {rx_shift[6:0], mosi_sync};
  assign frame_done = (state == CMD) && byte_done && (byte_cnt == 4'd4);

  // Bit counter and receive shift register; deselect realigns to a byte boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'hFF;
    end else if (ss_sync) begin
      bit_cnt  <= 3'd0;
    end else if (rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= rx_byte;
    end
  end

  // Parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_d;
  end

  // Parser next state: hunt for a start byte, collect five more, wait NCR fillers, shift out the response.
  always_comb begin
    state_d = state;
    if (ss_sync) begin
      state_d = HUNT;
    end else begin
      unique case (state)
        HUNT: if (byte_done && rx_byte[7:6] == 2'b01) state_d = CMD;
        CMD:  if (frame_done) state_d = WAIT;
        WAIT: if (byte_done && byte_cnt == NCR_LAST) state_d = RESP;
        RESP: if (fall && tx_bits == 6'd0) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Byte counter within the current parser state; saturates so long filler runs cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 4'd0;
    end else if (ss_sync || state_d != state) begin
      byte_cnt <= 4'd0;
    end else if (byte_done && byte_cnt != 4'hF) begin
      byte_cnt <= byte_cnt + 4'd1;
    end
  end

  // In HUNT the CRC restarts every byte, so a start byte leaves its own CRC behind.
  assign crc_seed = (state == HUNT && bit_cnt == 3'd0) ? 7'd0 : crc_q;

  sd_crc7_step u_crc (
    .crc_in  (crc_seed),
    .din     (mosi_sync),
    .crc_out (crc_next)
  );

  // Serial CRC7 over the start byte and the four argument bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 7'd0;
    end else if (rise && (state == HUNT || (state == CMD && byte_cnt < 4'd4))) begin
      crc_q <= crc_next;
    end
  end

  // Capture the index from the start byte and the argument bytes MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= 6'd0;
      arg_q <= 32'd0;
    end else if (state == HUNT && byte_done && rx_byte[7:6] == 2'b01) begin
      idx_q <= rx_byte[5:0];
    end else if (state == CMD && byte_done && byte_cnt < 4'd4) begin
      arg_q <= {arg_q[23:0], rx_byte};
    end
  end

  // Command decode: response and next card state, evaluated when the CRC byte lands.
  always_comb begin
    idle_d    = card_idle;
    app_d     = 1'b0;
    retry_d   = retry_q;
    long_resp = 1'b0;
    r1        = 8'h04 | {7'd0, card_idle};
    retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
    crc_ok    = (crc_q == rx_byte[7:1]) && rx_byte[0];
    if ((idx_q == 6'd0 || idx_q == 6'd8) && !crc_ok) begin
      r1    = 8'h08 | {7'd0, card_idle};
      app_d = app_q;
    end else begin
      case (idx_q)
        6'd0: begin
          idle_d  = 1'b1;
          retry_d = 4'd0;
          r1      = 8'h01;
        end
        6'd8: begin
          r1        = {7'd0, card_idle};
          long_resp = 1'b1;
        end
        6'd55: begin
          app_d = 1'b1;
          r1    = {7'd0, card_idle};
        end
        6'd41: begin
          if (app_q) begin
            retry_d = retry_inc;
            idle_d  = card_idle & (retry_inc < RETRY_LIM);
            r1      = {7'd0, idle_d};
          end
        end
        default: ;
      endcase
    end
  end

  // Card model state and the accepted-command outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      card_idle <= 1'b1;
      app_q     <= 1'b0;
      retry_q   <= 4'd0;
      cmd_valid <= 1'b0;
      cmd_index <= 6'd0;
      cmd_arg   <= 32'd0;
    end else begin
      cmd_valid <= frame_done;
      if (frame_done) begin
        card_idle <= idle_d;
        app_q     <= app_d;
        retry_q   <= retry_d;
        cmd_index <= idx_q;
        cmd_arg   <= arg_q;
      end
    end
  end

  // Response buffer: loaded at frame end, shifted one bit per falling edge while responding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q    <= '1;
      tx_bits <= 6'd0;
    end else if (frame_done) begin
      tx_q    <= long_resp ? {r1, 8'h00, 8'h00, 4'h0, arg_q[11:8], arg_q[7:0]}
                           : {r1, 32'hFFFF_FFFF};
      tx_bits <= long_resp ? 6'd40 : 6'd8;
    end else if (state == RESP && fall && tx_bits != 6'd0) begin
      tx_q    <= {tx_q[38:0], 1'b1};
      tx_bits <= tx_bits - 6'd1;
    end
  end

  // miso idles high and only moves on falling edges while a response is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso <= 1'b1;
    end else if (ss_sync || state != RESP) begin
      miso <= 1'b1;
    end else if (fall) begin
      miso <= (tx_bits == 6'd0) ? 1'b1 : tx_q[39];
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - randomized self-checking bench for sd_spi_responder
module tb_sd_spi_responder;
  localparam int NCR          = 1;
  localparam int INIT_RETRIES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b1;
  logic        miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        card_idle;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic [5:0]  last_idx = 6'd0;
  logic [31:0] last_arg = 32'd0;

  bit       m_idle = 1'b1;
  bit       m_app  = 1'b0;
  int       m_retry = 0;
  bit [7:0] exp_q[$];

  sd_spi_responder #(.NCR(NCR), .INIT_RETRIES(INIT_RETRIES)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso),
    .cmd_valid (cmd_valid),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .card_idle (card_idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      vcount   = vcount + 1;
      last_idx = cmd_index;
      last_arg = cmd_arg;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crcb);
    bit chk, ok;
    exp_q.delete();
    chk = (idx == 6'd0) || (idx == 6'd8);
    ok  = (crcb[7:1] == crc7_ref({2'b01, idx, arg})) && crcb[0];
    if (chk && !ok) begin
      exp_q.push_back(8'h08 | 8'(m_idle));
    end else if (idx == 6'd0) begin
      m_idle = 1; m_app = 0; m_retry = 0;
      exp_q.push_back(8'h01);
    end else if (idx == 6'd8) begin
      m_app = 0;
      exp_q.push_back(8'(m_idle));
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back({4'h0, arg[11:8]});
      exp_q.push_back(arg[7:0]);
    end else if (idx == 6'd55) begin
      m_app = 1;
      exp_q.push_back(8'(m_idle));
    end else if (idx == 6'd41 && m_app) begin
      m_app = 0;
      if (m_retry < 15) m_retry = m_retry + 1;
      if (m_retry >= INIT_RETRIES) m_idle = 0;
      exp_q.push_back(8'(m_idle));
    end else begin
      m_app = 0;
      exp_q.push_back(8'h04 | 8'(m_idle));
    end
  endtask

  task automatic xfer(input logic [7:0] tb, output logic [7:0] rb);
    rb = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = tb[i];
      #80;
      rb = {rb[6:0], miso};
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [47:0] f, input int njunk);
    logic [7:0] rb, acc, jb;
    int prev;
    @(negedge clk);
    model_cmd(f[45:40], f[39:8], f[7:0]);
    prev = vcount;
    acc  = 8'hFF;
    ss = 1'b0;
    #80;
    for (int j = 0; j < njunk; j++) begin
      jb = 8'($urandom);
      if (jb[7:6] == 2'b01) jb[7] = 1'b1;
      xfer(jb, rb);
      acc = acc & rb;
    end
    for (int j = 5; j >= 0; j--) begin
      xfer(f[j*8 +: 8], rb);
      acc = acc & rb;
    end
    check("miso_idle_during_cmd", acc, 8'hFF);
    for (int j = 0; j < NCR; j++) begin
      xfer(8'($urandom), rb);
      check("ncr_filler", rb, 8'hFF);
    end
    foreach (exp_q[k]) begin
      xfer(8'($urandom), rb);
      check($sformatf("resp_byte%0d_cmd%0d", k, f[45:40]), rb, exp_q[k]);
    end
    #50;
    check("miso_after_resp", miso, 1'b1);
    #30;
    ss = 1'b1;
    #200;
    check("cmd_valid_pulses", vcount - prev, 1);
    check("cmd_index", last_idx, f[45:40]);
    check("cmd_arg", last_arg, f[39:8]);
    check("card_idle", card_idle, m_idle);
  endtask

  function automatic logic [47:0] good_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  initial begin
    logic [7:0]  rb;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  crcb;
    int prev;

    #23;
    check("rst_miso", miso, 1'b1);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_index", cmd_index, 6'd0);
    check("rst_cmd_arg", cmd_arg, 32'd0);
    check("rst_card_idle", card_idle, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #100;

    do_frame(48'h40_0000_0000_95, 0);
    do_frame(48'h48_0000_01AA_87, 0);
    do_frame(48'h40_0000_0000_00, 0);
    do_frame(48'h51_0000_0000_FF, 1);
    for (int r = 0; r < 2; r++) begin
      do_frame(48'h77_0000_0000_FF, 0);
      do_frame(48'h69_4000_0000_FF, 0);
    end
    check("idle_after_acmd41", card_idle, 1'b0);

    // Abort mid-frame, then a full CMD0.
    @(negedge clk);
    prev = vcount;
    ss = 1'b0;
    #80;
    xfer(8'h48, rb); xfer(8'h00, rb); xfer(8'h00, rb);
    ss = 1'b1;
    #300;
    check("abort_no_valid", vcount - prev, 0);
    check("abort_card_idle", card_idle, m_idle);
    do_frame(48'h40_0000_0000_95, 2);

    // Randomized command mix with random leading junk.
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 5))
        0: idx = 6'd0;
        1: idx = 6'd8;
        2, 3: idx = 6'd55;
        4: idx = 6'd41;
        default: idx = 6'($urandom);
      endcase
      arg = $urandom;
      if ($urandom_range(0, 3) != 0) crcb = {crc7_ref({2'b01, idx, arg}), 1'b1};
      else crcb = 8'($urandom);
      do_frame({2'b01, idx, arg, crcb}, $urandom_range(0, 3));
    end

    // Reset while the R7 response is shifting out.
    @(negedge clk);
    ss = 1'b0;
    #80;
    xfer(8'h48, rb); xfer(8'h00, rb); xfer(8'h00, rb);
    xfer(8'h01, rb); xfer(8'hAA, rb); xfer(8'h87, rb);
    for (int j = 0; j < NCR; j++) xfer(8'hFF, rb);
    xfer(8'hFF, rb);
    mosi = 1'b1;
    #80;
    check("pre_rst_miso", miso, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_resp_miso", miso, 1'b1);
    check("rst_mid_resp_idle", card_idle, 1'b1);
    m_idle = 1; m_app = 0; m_retry = 0;
    #19;
    ss = 1'b1;
    #40;
    rst = 1'b0;
    #200;
    do_frame(48'h40_0000_0000_95, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
